pe_mac_seq: RTL and testbench

//  Upstream sequencer and downstream accumulator wrapped around the PE's serial shift-add multiplier.

---
 rtl/pe_pkg.sv | 29 ++
 rtl/pe_acc_unit.sv | 47 ++++
 rtl/pe_mac_seq.sv | 185 ++++++++++++++++++
 tb/tb_pe_mac_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared constants and helpers for the PE MAC sequencer.
// The accumulator overflow policy is selected with the PE_ACC_SAT_EN macro.
// That macro is used in pe_acc_unit and pe_mac_seq.
package pe_pkg;

  // Default accumulator headroom above the 2*BITWIDTH product width
  localparam int ACC_OFFSET = 8;

  // Sequencer state encoding (3 bits)
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_ISSUE  = 3'd1;
  localparam state_t S_SHIFT  = 3'd2;
  localparam state_t S_DRAIN  = 3'd3;
  localparam state_t S_RESULT = 3'd4;

  // Ceiling log2 for elaboration-time widths
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < unsigned'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/pe_acc_unit.sv
// pe_acc_unit: combinational accumulator adder for the PE MAC sequencer.
// When PE_ACC_SAT_EN is defined, a carry out of ACC_WIDTH clamps the sum to all-ones
// and raises the overflow flag, which then stays asserted while ovf_i is fed back.
// Without PE_ACC_SAT_EN the sum wraps modulo 2^ACC_WIDTH and ovf_o is 0.
module pe_acc_unit
  import pe_pkg::*;
#(
  parameter int PROD_WIDTH = 16,
  parameter int ACC_WIDTH  = 24
) (
  input  logic [ACC_WIDTH-1:0]  acc_i,
  input  logic [PROD_WIDTH-1:0] prod_i,
  input  logic                  ovf_i,
  output logic [ACC_WIDTH-1:0]  sum_o,
  output logic                  ovf_o
);

  logic [ACC_WIDTH:0] wide_s;

  // Zero-extended add that keeps one extra carry bit
  always_comb begin
    wide_s = {1'b0, acc_i} + {{(ACC_WIDTH - PROD_WIDTH + 1){1'b0}}, prod_i};
  end

`ifdef PE_ACC_SAT_EN
  // Clamp on carry-out; once overflowed, stay clamped until the flag is cleared upstream
  always_comb begin
    if (ovf_i || wide_s[ACC_WIDTH]) begin
      sum_o = {ACC_WIDTH{1'b1}};
      ovf_o = 1'b1;
    end else begin
      sum_o = wide_s[ACC_WIDTH-1:0];
      ovf_o = 1'b0;
    end
  end
`else
  logic unused_s;
  assign unused_s = ovf_i ^ wide_s[ACC_WIDTH];

  // Plain wrap-around; overflow is never reported
  always_comb begin
    sum_o = wide_s[ACC_WIDTH-1:0];
    ovf_o = 1'b0;
  end
`endif

endmodule

// File: rtl/pe_mac_seq.sv
// pe_mac_seq: operand sequencer and dot-product accumulator around a serial shift-add multiplier.
// Accepts (a, b, last) pairs, drives the multiplier through one load cycle and BITWIDTH-1
// shift cycles, then adds the product into the accumulator and emits the sum on the last pair.
// Overflow policy: PE_ACC_SAT_EN defined -> saturate with sticky acc_ovf; undefined -> wrap.
module pe_mac_seq
  import pe_pkg::*;
#(
  parameter int BITWIDTH  = 8,
  parameter int ACC_WIDTH = 2 * BITWIDTH + ACC_OFFSET
) (
  input  logic                         fast_clk,
  input  logic                         rst,
  input  logic                         op_valid,
  output logic                         op_ready,
  input  logic [BITWIDTH-1:0]          op_a,
  input  logic [BITWIDTH-1:0]          op_b,
  input  logic                         op_last,
  output logic                         mul_in_valid,
  output logic [BITWIDTH-1:0]          mul_din1,
  output logic [BITWIDTH-1:0]          mul_din2,
  output logic [clog2(BITWIDTH)+1:0]   mul_last_count,
  output logic                         mul_out_valid,
  input  logic [2*BITWIDTH-1:0]        mul_dout,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [ACC_WIDTH-1:0]         res_data,
  output logic                         acc_ovf
);

  localparam int            CW       = clog2(BITWIDTH) + 2;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BITWIDTH - 1);

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BITWIDTH-1:0]    a_q, a_d, b_q, b_d;
  logic                   last_q, last_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   ovf_q, ovf_d;

  logic                   op_ready_q, op_ready_d;
  logic                   mul_in_valid_q, mul_in_valid_d;
  logic                   mul_out_valid_q, mul_out_valid_d;
  logic [CW-1:0]          mul_last_count_q, mul_last_count_d;
  logic                   res_valid_q, res_valid_d;
  logic [ACC_WIDTH-1:0]   res_data_q, res_data_d;

  logic [ACC_WIDTH-1:0]   sum_s;
  logic                   ovf_s;

  pe_acc_unit #(
    .PROD_WIDTH (2 * BITWIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_acc (
    .acc_i  (acc_q),
    .prod_i (mul_dout),
    .ovf_i  (ovf_q),
    .sum_o  (sum_s),
    .ovf_o  (ovf_s)
  );

  // State register: all flops, synchronous active-low reset clears everything
  always_ff @(posedge fast_clk) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      a_q              <= '0;
      b_q              <= '0;
      last_q           <= 1'b0;
      acc_q            <= '0;
      ovf_q            <= 1'b0;
      op_ready_q       <= 1'b0;
      mul_in_valid_q   <= 1'b0;
      mul_out_valid_q  <= 1'b0;
      mul_last_count_q <= '0;
      res_valid_q      <= 1'b0;
      res_data_q       <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      a_q              <= a_d;
      b_q              <= b_d;
      last_q           <= last_d;
      acc_q            <= acc_d;
      ovf_q            <= ovf_d;
      op_ready_q       <= op_ready_d;
      mul_in_valid_q   <= mul_in_valid_d;
      mul_out_valid_q  <= mul_out_valid_d;
      mul_last_count_q <= mul_last_count_d;
      res_valid_q      <= res_valid_d;
      res_data_q       <= res_data_d;
    end
  end

  // Next-state logic plus operand latch, bit counter and accumulator updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    last_d  = last_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid && op_ready_q) begin
          a_d     = op_a;
          b_d     = op_b;
          last_d  = op_last;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_ONE;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_DRAIN: begin
        acc_d = sum_s;
        ovf_d = ovf_s;
        cnt_d = '0;
        if (last_q) begin
          state_d = S_RESULT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RESULT: begin
        if (res_valid_q && res_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_RESULT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output comes straight from a flop
  always_comb begin
    op_ready_d      = (state_d == S_IDLE);
    mul_in_valid_d  = (state_d == S_ISSUE);
    mul_out_valid_d = (state_d == S_DRAIN);
    res_valid_d     = (state_d == S_RESULT);
    if (state_d == S_SHIFT) begin
      mul_last_count_d = cnt_d;
    end else begin
      mul_last_count_d = '0;
    end
    if (state_d == S_RESULT) begin
      res_data_d = acc_d;
    end else begin
      res_data_d = '0;
    end
  end

  assign op_ready       = op_ready_q;
  assign mul_in_valid   = mul_in_valid_q;
  assign mul_out_valid  = mul_out_valid_q;
  assign mul_last_count = mul_last_count_q;
  assign mul_din1       = a_q;
  assign mul_din2       = b_q;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;

`ifdef PE_ACC_SAT_EN
  assign acc_ovf = ovf_q;
`else
  assign acc_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pe_mac_seq.sv
// tb_pe_mac_seq: scoreboard bench for pe_mac_seq with a serial shift-add multiplier model.
// Expected dot products come from plain integer arithmetic; PE_ACC_SAT_EN selects the
// saturating or wrapping reference behaviour to match the DUT build.
module tb_pe_mac_seq;
  import pe_pkg::*;

  localparam int BW = 8;
  localparam int AW = 16;
  localparam int CW = clog2(BW) + 2;

  logic            fast_clk;
  logic            rst;
  logic            op_valid;
  logic            op_ready;
  logic [BW-1:0]   op_a;
  logic [BW-1:0]   op_b;
  logic            op_last;
  logic            mul_in_valid;
  logic [BW-1:0]   mul_din1;
  logic [BW-1:0]   mul_din2;
  logic [CW-1:0]   mul_last_count;
  logic            mul_out_valid;
  logic [2*BW-1:0] mul_dout;
  logic            res_valid;
  logic            res_ready;
  logic [AW-1:0]   res_data;
  logic            acc_ovf;

  pe_mac_seq #(
    .BITWIDTH  (BW),
    .ACC_WIDTH (AW)
  ) dut (
    .fast_clk       (fast_clk),
    .rst            (rst),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .op_a           (op_a),
    .op_b           (op_b),
    .op_last        (op_last),
    .mul_in_valid   (mul_in_valid),
    .mul_din1       (mul_din1),
    .mul_din2       (mul_din2),
    .mul_last_count (mul_last_count),
    .mul_out_valid  (mul_out_valid),
    .mul_dout       (mul_dout),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .acc_ovf        (acc_ovf)
  );

  typedef struct {
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    int            c;
  } acc_t;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          stall_left = 0;
  int          last_issue = -1000;
  longint      model_acc = 0;
  bit          model_ovf = 1'b0;
  logic [AW:0] exp_q[$];
  acc_t        pend_q[$];

  initial begin
    fast_clk = 1'b0;
    forever #5 fast_clk = ~fast_clk;
  end

  always @(posedge fast_clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Serial shift-add multiplier model: load on mul_in_valid, add shifted partials per bit index
  logic [BW-1:0]   ma, mb;
  logic [2*BW-1:0] mp;
  logic            mbusy;
  assign mul_dout = mp;

  always @(posedge fast_clk) begin
    if (!rst) begin
      mp <= '0; mbusy <= 1'b0; ma <= '0; mb <= '0;
    end else if (mul_out_valid) begin
      mp <= '0; mbusy <= 1'b0;
    end else if (mul_in_valid) begin
      ma <= mul_din1; mb <= mul_din2; mbusy <= 1'b1;
      mp <= mul_din2[0] ? {{BW{1'b0}}, mul_din1} : '0;
    end else if (mbusy) begin
      if (mb[mul_last_count]) mp <= mp + ({{BW{1'b0}}, ma} << mul_last_count);
    end
  end

  // Reference: running dot product with wrap or saturation
  function automatic void model_add(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic last);
    longint s;
    s = model_acc + longint'(a) * longint'(b);
`ifdef PE_ACC_SAT_EN
    if (model_ovf || s > ((longint'(1) << AW) - 1)) begin
      model_acc = (longint'(1) << AW) - 1;
      model_ovf = 1'b1;
    end else begin
      model_acc = s;
    end
`else
    model_acc = s % (longint'(1) << AW);
    model_ovf = 1'b0;
`endif
    if (last) begin
      exp_q.push_back({model_ovf, model_acc[AW-1:0]});
      model_acc = 0;
      model_ovf = 1'b0;
    end
  endfunction

  // Result consumer: optionally withholds res_ready for stall_left cycles once res_valid shows
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge fast_clk);
      #1;
      if (res_valid && stall_left > 0) begin
        res_ready = 1'b0;
        stall_left--;
      end else begin
        res_ready = 1'b1;
      end
    end
  end

  // Monitor: checks issue timing/operands, drain timing and results against the scoreboard
  initial begin
    acc_t        p;
    logic [AW:0] e;
    forever begin
      @(negedge fast_clk);
      if (rst) begin
        if (mul_in_valid) begin
          if (pend_q.size() == 0) begin
            check("unexpected_issue", 32'd1, 32'd0);
          end else begin
            p = pend_q.pop_front();
            check("issue_latency", cyc, p.c + 1);
            check("issue_din1", {24'd0, mul_din1}, {24'd0, p.a});
            check("issue_din2", {24'd0, mul_din2}, {24'd0, p.b});
            check("issue_count", {27'd0, mul_last_count}, 32'd0);
            last_issue = cyc;
          end
        end
        if (mul_out_valid) check("drain_latency", cyc, last_issue + BW);
        if (res_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
          end else if (res_ready) begin
            e = exp_q.pop_front();
            check("res_data", {16'd0, res_data}, {16'd0, e[AW-1:0]});
            check("acc_ovf", {31'd0, acc_ovf}, {31'd0, e[AW]});
          end else begin
            e = exp_q[0];
            check("stall_res_data", {16'd0, res_data}, {16'd0, e[AW-1:0]});
            check("stall_op_ready", {31'd0, op_ready}, 32'd0);
            check("stall_no_issue", {31'd0, mul_in_valid}, 32'd0);
          end
        end
      end
    end
  end

  task automatic send_pair(input logic [BW-1:0] ai, input logic [BW-1:0] bi, input logic last,
                           output int acc_c);
    int waited;
    bit done;
    waited = 0;
    done = 1'b0;
    acc_c = -1;
    op_a = ai; op_b = bi; op_last = last; op_valid = 1'b1;
    while (!done && waited < 200) begin
      @(negedge fast_clk);
      if (op_ready) begin
        acc_c = cyc;
        pend_q.push_back('{ai, bi, cyc});
        model_add(ai, bi, last);
        done = 1'b1;
      end
      @(posedge fast_clk);
      #1;
      waited++;
    end
    op_valid = 1'b0;
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    @(posedge fast_clk);
    @(negedge fast_clk);
    check("rst_ctrl", {27'd0, op_ready, mul_in_valid, mul_out_valid, res_valid, acc_ovf}, 32'd0);
    check("rst_mul", {11'd0, mul_din1, mul_din2, mul_last_count}, 32'd0);
    check("rst_res", {16'd0, res_data}, 32'd0);
    repeat (cycles) @(posedge fast_clk);
    #1;
    rst = 1'b1;
    model_acc = 0;
    model_ovf = 1'b0;
    pend_q.delete();
    @(posedge fast_clk);
    @(negedge fast_clk);
    check("op_ready_after_rst", {31'd0, op_ready}, 32'd1);
    @(posedge fast_clk);
    #1;
  endtask

  task automatic wait_drain();
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || pend_q.size() != 0) && waited < 1000) begin
      @(posedge fast_clk);
      waited++;
    end
    #1;
    check("drain_timeout", exp_q.size() + pend_q.size(), 32'd0);
  endtask

  initial begin
    int c_prev, c_now, len;
    rst = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0; op_last = 1'b0;
    repeat (2) @(posedge fast_clk);
    #1;
    do_reset(2);

    // single pair 3*5
    send_pair(8'd3, 8'd5, 1'b1, c_now);
    wait_drain();

    // three-term vector -> 44
    send_pair(8'd1, 8'd2, 1'b0, c_now);
    send_pair(8'd3, 8'd4, 1'b0, c_now);
    send_pair(8'd5, 8'd6, 1'b1, c_now);
    wait_drain();

    // result backpressure for 5 cycles, then a single pair proves acc was cleared
    stall_left = 5;
    send_pair(8'd7, 8'd9, 1'b0, c_now);
    send_pair(8'd10, 8'd10, 1'b1, c_now);
    send_pair(8'd1, 8'd1, 1'b1, c_now);
    wait_drain();

    // reset during SHIFT of a 2-pair vector, then 2*2
    send_pair(8'd9, 8'd9, 1'b0, c_now);
    repeat (3) @(posedge fast_clk);
    #1;
    do_reset(1);
    send_pair(8'd2, 8'd2, 1'b1, c_now);
    wait_drain();

    // 16-bit accumulator overflow: two 255*255 products
    send_pair(8'd255, 8'd255, 1'b0, c_now);
    send_pair(8'd255, 8'd255, 1'b1, c_now);
    wait_drain();

    // back-to-back with op_valid continuously high
    send_pair(8'd1, 8'd1, 1'b0, c_prev);
    for (int i = 0; i < 3; i++) begin
      send_pair(BW'(i + 2), BW'(i + 3), (i == 2), c_now);
      check("b2b_period", c_now - c_prev, BW + 2);
      c_prev = c_now;
    end
    wait_drain();

    // randomized vectors with random gaps and result stalls
    for (int v = 0; v < 25; v++) begin
      len = $urandom_range(1, 4);
      stall_left = $urandom_range(0, 3);
      for (int k = 0; k < len; k++) begin
        send_pair(BW'($urandom_range(0, 255)), BW'($urandom_range(0, 255)), (k == len - 1), c_now);
        repeat ($urandom_range(0, 2)) @(posedge fast_clk);
        #1;
      end
    end
    wait_drain();

    repeat (5) @(posedge fast_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
